// File: rtl/puf_win_cntr.sv
// ---------------------------------------------------------------------------
// puf_win_cntr
//
// Purpose:
//   Multi-channel windowed event counter for the PUF datapath. After an
//   accepted start it counts per-channel event strobes for a programmable
//   number of clock cycles, then freezes the counts. One response bit per
//   channel pair is derived by unsigned magnitude comparison, and the result
//   is held behind a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   i_start    single-cycle request to start a window (honoured only in IDLE)
//   i_win_len  window length in cycles, latched on an accepted start
//   i_clr      synchronous abort back to IDLE, clears the result
//   i_evt      per-channel event strobes, one event per high cycle
//   i_ready    downstream accepts the result
//   o_busy     high while counting or holding a result
//   o_valid    result valid, held until accepted
//   o_count    frozen counts, channel c at [c*CNT_W +: CNT_W]
//   o_resp     o_resp[k] = count[2k] > count[2k+1]
//   o_tie      o_tie[k]  = count[2k] == count[2k+1]
//   o_sat      per-channel saturation flags
//
// Configuration:
//   PUF_WIN_CNTR_SAT_EN  when defined, channel counters saturate at all-ones
//                        and flag the channel in o_sat; otherwise counters
//                        wrap and o_sat stays 0.
// ---------------------------------------------------------------------------
module puf_win_cntr #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [WIN_W-1:0]        i_win_len,
  input  logic                    i_clr,
  input  logic [NUM_CH-1:0]       i_evt,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic [NUM_CH*CNT_W-1:0] o_count,
  output logic [NUM_CH/2-1:0]     o_resp,
  output logic [NUM_CH/2-1:0]     o_tie,
  output logic [NUM_CH-1:0]       o_sat
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [WIN_W-1:0] WIN_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [WIN_W-1:0]          r_win_len;
  logic [WIN_W-1:0]          r_win_cnt;
  logic [NUM_CH*CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]         r_sat_acc;

  logic [NUM_CH*CNT_W-1:0]   r_count;
  logic [NUM_CH/2-1:0]       r_resp;
  logic [NUM_CH/2-1:0]       r_tie;
  logic [NUM_CH-1:0]         r_sat;
  logic                      r_valid;

  logic [NUM_CH*CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_CH-1:0]         w_sat_nxt;
  logic [NUM_CH/2-1:0]       w_resp;
  logic [NUM_CH/2-1:0]       w_tie;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_handshake;

  // A start with a zero length is dropped so that a window always has at
  // least one sampled cycle and the length-1 compare below cannot underflow.
  assign w_accept    = (r_state == IDLE) && i_start && (i_win_len != '0);
  // The final window cycle is the one whose events are still folded into the
  // frozen result, so the compare is against length-1 on the current count.
  assign w_last      = (r_state == COUNT) && (r_win_cnt == (r_win_len - WIN_ONE));
  assign w_handshake = (r_state == HOLD) && r_valid && i_ready;

  // Next value of every channel counter including this cycle's events. In the
  // saturating build a counter already at all-ones stays there and records
  // that an event was lost; otherwise the counter simply wraps.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat_acc;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_evt[c]) begin
`ifdef PUF_WIN_CNTR_SAT_EN
        if (r_cnt[c*CNT_W +: CNT_W] == {CNT_W{1'b1}}) begin
          w_sat_nxt[c] = 1'b1;
        end else begin
          w_cnt_nxt[c*CNT_W +: CNT_W] = r_cnt[c*CNT_W +: CNT_W] + CNT_ONE;
        end
`else
        w_cnt_nxt[c*CNT_W +: CNT_W] = r_cnt[c*CNT_W +: CNT_W] + CNT_ONE;
`endif
      end
    end
`ifndef PUF_WIN_CNTR_SAT_EN
    w_sat_nxt = '0;
`endif
  end

  // Pairwise unsigned comparison on the counts as they will be frozen. A tie
  // reports resp=0 and tie=1 so downstream can discard unreliable bits.
  always_comb begin
    w_resp = '0;
    w_tie  = '0;
    for (int k = 0; k < NUM_CH/2; k++) begin
      w_resp[k] = w_cnt_nxt[(2*k)*CNT_W +: CNT_W] > w_cnt_nxt[(2*k+1)*CNT_W +: CNT_W];
      w_tie[k]  = w_cnt_nxt[(2*k)*CNT_W +: CNT_W] == w_cnt_nxt[(2*k+1)*CNT_W +: CNT_W];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Abort has priority over everything, including a start
  // or a handshake arriving in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clr) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept)    w_state_nxt = COUNT;
        COUNT:   if (w_last)      w_state_nxt = HOLD;
        HOLD:    if (w_handshake) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: window/channel counters while counting, and the frozen result
  // registers. The result is only written on the last window cycle, so it is
  // stable throughout HOLD and after the handshake until the next window ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_len <= '0;
      r_win_cnt <= '0;
      r_cnt     <= '0;
      r_sat_acc <= '0;
      r_count   <= '0;
      r_resp    <= '0;
      r_tie     <= '0;
      r_sat     <= '0;
      r_valid   <= 1'b0;
    end else if (i_clr) begin
      r_count   <= '0;
      r_resp    <= '0;
      r_tie     <= '0;
      r_sat     <= '0;
      r_valid   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_win_len <= i_win_len;
            r_win_cnt <= '0;
            r_cnt     <= '0;
            r_sat_acc <= '0;
          end
        end
        COUNT: begin
          r_cnt     <= w_cnt_nxt;
          r_sat_acc <= w_sat_nxt;
          r_win_cnt <= r_win_cnt + WIN_ONE;
          if (w_last) begin
            r_count <= w_cnt_nxt;
            r_resp  <= w_resp;
            r_tie   <= w_tie;
            r_sat   <= w_sat_nxt;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_handshake) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = (r_state == COUNT) || (r_state == HOLD);
  assign o_valid = r_valid;
  assign o_count = r_count;
  assign o_resp  = r_resp;
  assign o_tie   = r_tie;
  assign o_sat   = r_sat;

endmodule

// File: tb/tb_puf_win_cntr.sv
// ---------------------------------------------------------------------------
// tb_puf_win_cntr
//
// Directed self-checking bench for puf_win_cntr, built with 4-bit channel
// counters so that a 20-cycle window exercises counter overflow. Inputs are
// changed on the falling edge and outputs are sampled on the falling edge,
// half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_puf_win_cntr;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 10;

  logic                    clk;
  logic                    rst;
  logic                    iStart;
  logic [WIN_W-1:0]        iWinLen;
  logic                    iClr;
  logic [NUM_CH-1:0]       iEvt;
  logic                    iReady;
  logic                    oBusy;
  logic                    oValid;
  logic [NUM_CH*CNT_W-1:0] oCount;
  logic [NUM_CH/2-1:0]     oResp;
  logic [NUM_CH/2-1:0]     oTie;
  logic [NUM_CH-1:0]       oSat;

  int total;
  int bad;

  puf_win_cntr #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (iStart),
    .i_win_len(iWinLen),
    .i_clr    (iClr),
    .i_evt    (iEvt),
    .i_ready  (iReady),
    .o_busy   (oBusy),
    .o_valid  (oValid),
    .o_count  (oCount),
    .o_resp   (oResp),
    .o_tie    (oTie),
    .o_sat    (oSat)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, then wait until the following falling
  // edge so the rising edge in between has consumed them.
  task automatic applyStimulus(input logic start, input logic [WIN_W-1:0] winLen,
                               input logic [NUM_CH-1:0] evt, input logic ready,
                               input logic clr);
    iStart  = start;
    iWinLen = winLen;
    iEvt    = evt;
    iReady  = ready;
    iClr    = clr;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    iStart  = 1'b0;
    iWinLen = '0;
    iClr    = 1'b0;
    iEvt    = '0;
    iReady  = 1'b0;

    // Reset values
    applyStimulus(0, 0, 4'b0000, 0, 0);
    applyStimulus(0, 0, 4'b0000, 0, 0);
    checkOutput("rst_busy",  32'(oBusy),  32'h0);
    checkOutput("rst_valid", 32'(oValid), 32'h0);
    checkOutput("rst_count", 32'(oCount), 32'h0);
    checkOutput("rst_resp",  32'(oResp),  32'h0);
    checkOutput("rst_tie",   32'(oTie),   32'h0);
    checkOutput("rst_sat",   32'(oSat),   32'h0);
    rst = 1'b0;
    applyStimulus(0, 0, 4'b0000, 0, 0);

    // Window of 10: ch0 every cycle, ch1 every other cycle, ch2/ch3 idle
    applyStimulus(1, 10, 4'b0000, 0, 0);
    checkOutput("win_busy", 32'(oBusy), 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) checkOutput("win_valid_early", 32'(oValid), 32'h0);
      applyStimulus(0, 0, {2'b00, (i % 2 == 0), 1'b1}, 0, 0);
    end
    checkOutput("win_valid", 32'(oValid), 32'h1);
    checkOutput("win_count", 32'(oCount), 32'h005A);
    checkOutput("win_resp",  32'(oResp),  32'h1);
    checkOutput("win_tie",   32'(oTie),   32'h2);
    checkOutput("win_sat",   32'(oSat),   32'h0);

    // Backpressure: result holds and starts are ignored
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 3, 4'b1111, 0, 0);
      checkOutput("bp_valid", 32'(oValid), 32'h1);
      checkOutput("bp_count", 32'(oCount), 32'h005A);
      checkOutput("bp_busy",  32'(oBusy),  32'h1);
    end
    applyStimulus(0, 0, 4'b0000, 1, 0);
    checkOutput("hs_valid", 32'(oValid), 32'h0);
    checkOutput("hs_busy",  32'(oBusy),  32'h0);

    // New start right after the handshake, then reset mid-window
    applyStimulus(1, 5, 4'b1111, 1, 0);
    checkOutput("restart_busy", 32'(oBusy), 32'h1);
    applyStimulus(0, 0, 4'b1111, 1, 0);
    applyStimulus(0, 0, 4'b1111, 1, 0);
    rst = 1'b1;
    #1;
    checkOutput("arst_busy",  32'(oBusy),  32'h0);
    checkOutput("arst_valid", 32'(oValid), 32'h0);
    checkOutput("arst_count", 32'(oCount), 32'h0);
    checkOutput("arst_tie",   32'(oTie),   32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Window of 5 with all channels active, ready already high
    applyStimulus(1, 5, 4'b0000, 1, 0);
    checkOutput("all_busy", 32'(oBusy), 32'h1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'b1111, 1, 0);
    checkOutput("all_valid", 32'(oValid), 32'h1);
    checkOutput("all_count", 32'(oCount), 32'h5555);
    checkOutput("all_resp",  32'(oResp),  32'h0);
    checkOutput("all_tie",   32'(oTie),   32'h3);
    applyStimulus(0, 0, 4'b0000, 1, 0);
    checkOutput("all_valid_1cyc", 32'(oValid), 32'h0);
    checkOutput("all_busy_done",  32'(oBusy),  32'h0);

    // Zero-length start is ignored
    applyStimulus(1, 0, 4'b0000, 0, 0);
    checkOutput("zlen_busy", 32'(oBusy), 32'h0);

    // Abort wins over a simultaneous start
    applyStimulus(1, 5, 4'b0000, 0, 1);
    checkOutput("clrstart_busy", 32'(oBusy), 32'h0);

    // Abort while holding a result
    applyStimulus(1, 2, 4'b0000, 0, 0);
    checkOutput("h_busy", 32'(oBusy), 32'h1);
    applyStimulus(0, 0, 4'b0010, 0, 0);
    applyStimulus(0, 0, 4'b0010, 0, 0);
    checkOutput("h_valid", 32'(oValid), 32'h1);
    checkOutput("h_count", 32'(oCount), 32'h0020);
    checkOutput("h_resp",  32'(oResp),  32'h0);
    checkOutput("h_tie",   32'(oTie),   32'h2);
    applyStimulus(0, 0, 4'b0000, 0, 1);
    checkOutput("hclr_valid", 32'(oValid), 32'h0);
    checkOutput("hclr_busy",  32'(oBusy),  32'h0);
    checkOutput("hclr_count", 32'(oCount), 32'h0);
    checkOutput("hclr_tie",   32'(oTie),   32'h0);

    // Overflow: 20 events on ch0 into a 4-bit counter
    applyStimulus(1, 20, 4'b0000, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 4'b0001, 0, 0);
    checkOutput("ovf_valid", 32'(oValid), 32'h1);
`ifdef PUF_WIN_CNTR_SAT_EN
    checkOutput("ovf_count", 32'(oCount), 32'h000F);
    checkOutput("ovf_sat",   32'(oSat),   32'h1);
`else
    checkOutput("ovf_count", 32'(oCount), 32'h0004);
    checkOutput("ovf_sat",   32'(oSat),   32'h0);
`endif
    checkOutput("ovf_resp", 32'(oResp), 32'h1);
    checkOutput("ovf_tie",  32'(oTie),  32'h2);
    applyStimulus(0, 0, 4'b0000, 1, 0);
    checkOutput("ovf_hs_valid", 32'(oValid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
